// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning the HI/LO register pair
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic [CW-1:0] w_n;
    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_q;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_res;
    logic        w_wr_ok;

    assign w_n = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // Low 64 bits of a 64x64 product of sign-extended operands give the signed product
    assign w_sprod = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_uprod = {32'b0, r_a} * {32'b0, r_b};

    // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000
    assign w_signed = ~r_op[0];
    assign w_neg_a  = w_signed & r_a[31];
    assign w_neg_q  = w_signed & (r_a[31] ^ r_b[31]);
    assign w_mag_a  = w_neg_a ? (~r_a + 32'd1) : r_a;
    assign w_mag_b  = (w_signed & r_b[31]) ? (~r_b + 32'd1) : r_b;
    assign w_q      = w_mag_a / w_mag_b;
    assign w_r      = w_mag_a % w_mag_b;

    assign w_res   = r_op[1] ? {w_neg_a ? -w_r : w_r, w_neg_q ? -w_q : w_q}
                             : (r_op[0] ? w_uprod : w_sprod);
    assign w_wr_ok = ~r_op[1] | (r_b != 32'd0);

    // IDLE/BUSY sequencing, operand capture, result commit and MTHI/MTLO writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_op    <= op;
                r_a     <= src_a;
                r_b     <= src_b;
                r_cnt   <= w_n;
                r_state <= S_BUSY;
                r_busy  <= 1'b1;
            end else begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end else if (r_cnt == CW'(1)) begin
            if (w_wr_ok) {r_hi, r_lo} <= w_res;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign busy  = r_busy;
    assign stall = md_use & (r_busy | start);
    assign hi    = r_hi;
    assign lo    = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against an arithmetic model
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    int          m_left = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    bit          m_pok;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .md_use(md_use),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout busy=%b", busy);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output bit ok);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ok = 1;
        h = 0;
        l = 0;
        case (o)
            2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
            2'd2: begin
                ok = (b != 0);
                if (ok) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            default: begin
                ok = (b != 0);
                if (ok) begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // One clock: check stall before the edge, advance the model at the edge, check registers after
    task automatic step();
        #1;
        chk("stall", {31'b0, stall}, {31'b0, md_use & ((m_left > 0) | start)});
        @(posedge clk);
        if (reset) begin
            m_left = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (start) begin
            model_op(op, src_a, src_b, m_phi, m_plo, m_pok);
            m_left = op[1] ? 10 : 5;
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
        end
        #1;
        chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        op = o; src_a = a; src_b = b; start = 1;
        step();
        start = 0;
        n = 0;
        while (busy && n < 40) begin n++; step(); end
    endtask

    initial begin
        int n;
        reset = 1; start = 0; op = 0; src_a = 0; src_b = 0;
        hi_we = 0; lo_we = 0; wdata = 0; md_use = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 0;

        run_op(2'd0, 32'hFFFFFFFE, 32'd3, n);
        chk("mult_cycles", n, 5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        run_op(2'd1, 32'hFFFFFFFF, 32'd2, n);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        run_op(2'd2, 32'hFFFFFFF9, 32'd2, n);
        chk("div_cycles", n, 10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run_op(2'd3, 32'd7, 32'd0, n);
        chk("divz_cycles", n, 10);
        chk("divz_lo", lo, 32'hFFFFFFFD);
        chk("divz_hi", hi, 32'hFFFFFFFF);

        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, n);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);

        md_use = 1;
        op = 2'd2; src_a = 32'd100; src_b = 32'd7; start = 1;
        step();
        start = 0;
        n = 0;
        repeat (4) begin n++; step(); end
        hi_we = 1; wdata = 32'h1234; src_a = 32'd999; src_b = 32'd1; start = 1; op = 2'd0;
        chk("stall_busy", {31'b0, stall}, 32'd1);
        n++; step();
        hi_we = 0; start = 0;
        while (busy && n < 40) begin n++; step(); end
        chk("div2_cycles", n, 10);
        chk("div2_hi", hi, 32'd2);
        chk("div2_lo", lo, 32'd14);
        md_use = 0;

        hi_we = 1; lo_we = 1; wdata = 32'hA5A5A5A5;
        step();
        hi_we = 0; lo_we = 0;
        chk("mt_hi", hi, 32'hA5A5A5A5);
        chk("mt_lo", lo, 32'hA5A5A5A5);
        lo_we = 1; wdata = 32'hDEAD;
        run_op(2'd0, 32'd4, 32'd5, n);
        lo_we = 0;
        chk("prio_lo", lo, 32'd20);
        chk("prio_hi", hi, 32'd0);

        op = 2'd0; src_a = 32'd5; src_b = 32'd7; start = 1;
        step();
        start = 0;
        step();
        step();
        #3;
        reset = 1;
        #1;
        m_left = 0; m_hi = 0; m_lo = 0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        step();
        reset = 0;
        run_op(2'd0, 32'd2, 32'd3, n);
        chk("after_rst_lo", lo, 32'd6);
        chk("after_rst_cycles", n, 5);

        for (int i = 0; i < 600; i++) begin
            start = ($urandom % 5) == 0;
            op = 2'($urandom);
            case ($urandom % 4)
                0: src_a = 32'h80000000;
                1: src_a = $urandom % 64;
                default: src_a = $urandom;
            endcase
            case ($urandom % 6)
                0: src_b = 32'd0;
                1: src_b = 32'hFFFFFFFF;
                2: src_b = ($urandom % 16) - 8;
                default: src_b = $urandom;
            endcase
            hi_we = ($urandom % 4) == 0;
            lo_we = ($urandom % 4) == 0;
            wdata = $urandom;
            md_use = $urandom % 2;
            if (($urandom % 120) == 0) begin
                reset = 1; m_left = 0; m_hi = 0; m_lo = 0;
            end else begin
                reset = 0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  issue pulse from the EX stage for a multiply or divide.
REQ-006 SHALL have port op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port src_a  input  32  operand rs, which is the dividend for DIV/DIVU.
REQ-008 SHALL have port src_b  input  32  operand rt, which is the divisor for DIV/DIVU.
REQ-009 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-010 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-011 SHALL have port wdata  input  32  data written by MTHI or MTLO.
REQ-012 SHALL have port md_use  input  1  decode stage holds an MDU-class instruction (MULT*, DIV*, MFHI, MFLO, MTHI, MTLO).
REQ-013 SHALL have port busy  output  1  an operation is in flight.
REQ-014 SHALL have port stall  output  1  pipeline stall request to F/D.
REQ-015 SHALL have port hi  output  32  HI register.
REQ-016 SHALL have port lo  output  32  LO register.

Function
REQ-017 SHALL implement a two-state FSM (IDLE, BUSY) plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-018 In IDLE with start=1 at edge E0: latch op, src_a, src_b; enter BUSY; load the counter with the cycle count for op.
REQ-019 busy SHALL equal 1 for exactly N cycles following E0 (N = MULT_CYCLES or DIV_CYCLES) and 0 in all other cycles.
REQ-020 At the edge ending the Nth busy cycle: HI/LO SHALL be written, FSM SHALL return to IDLE, and the new HI/LO SHALL be visible in the next cycle.
REQ-021 MULT SHALL write {hi,lo} = signed 64-bit product; MULTU SHALL write {hi,lo} = unsigned 64-bit product.
REQ-022 DIV SHALL write lo = signed quotient truncated toward zero and hi = remainder carrying the dividend's sign; DIVU SHALL write the unsigned quotient and remainder.
REQ-023 On divide by zero (latched src_b == 0) hi and lo SHALL remain unchanged; timing still follows DIV_CYCLES.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-025 start while BUSY SHALL be ignored, with no restart and no relatch.
REQ-026 hi_we/lo_we in IDLE SHALL write wdata at that edge; they SHALL be ignored while BUSY and in the cycle start=1.
REQ-027 If hi_we and lo_we are both 1, both registers SHALL take wdata.
REQ-028 A start accepted in IDLE SHALL take priority over hi_we/lo_we presented in the same cycle.
REQ-029 stall SHALL equal md_use & (busy | start), combinationally.
REQ-030 Operand latches SHALL hold across the entire operation; changes on src_a/src_b during BUSY SHALL have no effect.

Reset
REQ-031 reset=1 SHALL immediately force FSM=IDLE, counter=0, busy=0, hi=0, lo=0, and operand latches=0; stall then depends only on start and md_use.
REQ-032 reset asserted mid-operation SHALL abort it with no HI/LO write; after release the block SHALL accept a new start on the first edge.

Verification
REQ-033 MULT with src_a=0xFFFFFFFE (-2) and src_b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 MULTU with src_a=0xFFFFFFFF and src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-035 DIV with src_a=-7 and src_b=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with 7 and 0 -> hi/lo unchanged.
REQ-036 Start DIV with md_use=1 held -> stall=1 from the start cycle through the last busy cycle; hi_we pulsed mid-BUSY with wdata=0x1234 -> hi not 0x1234.
REQ-037 Start MULT, then assert reset asynchronously in busy cycle 3 -> busy=0, hi=lo=0 immediately; a MULT of 2*3 started after release yields lo=6.
REQ-038 In IDLE, hi_we=lo_we=1 with wdata=0xA5A5A5A5 -> both registers read 0xA5A5A5A5 next cycle; start presented in the same cycle as lo_we -> lo receives the product, not wdata.
